// File: rtl/rom_sched_defs_pkg.sv
// Shared definitions for the image-ROM port scheduler: default widths and the
// 2-bit in-flight read tag encoding used by the scheduler and its clients.
package rom_sched_defs;

    localparam int unsigned DEF_ADDR_WIDTH  = 16;
    localparam int unsigned DEF_DATA_WIDTH  = 24;
    localparam int unsigned DEF_ROM_LATENCY = 2;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'b00;
    localparam tag_t TAG_VGA  = 2'b01;
    localparam tag_t TAG_AUX  = 2'b10;

    // At most one requester wins a cycle, so VGA takes precedence in the encoding.
    function automatic tag_t tag_encode(input logic vga_issue, input logic aux_issue);
        tag_t tag;
        if (vga_issue) begin
            tag = TAG_VGA;
        end else if (aux_issue) begin
            tag = TAG_AUX;
        end else begin
            tag = TAG_NONE;
        end
        return tag;
    endfunction

endpackage

// File: rtl/rom_port_scheduler_tag_pipe.sv
// Fixed-depth shift register of read tags; follows each issued ROM read until
// its data appears on the ROM output.
module rom_tag_pipe
    import rom_sched_defs::*;
#(
    parameter int unsigned p_depth = 3
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_r [p_depth];

    // Shift tags every cycle; reset discards all in-flight reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(p_depth); i++) begin
                stage_r[i] <= TAG_NONE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < int'(p_depth); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[p_depth-1];

endmodule

// File: rtl/rom_port_scheduler.sv
// Shares the image ROM read port between the VGA fetch path (absolute priority)
// and an auxiliary requester, returning data with per-requester valids.
module rom_port_scheduler
    import rom_sched_defs::*;
#(
    parameter int unsigned p_addr_width   = DEF_ADDR_WIDTH,
    parameter int unsigned p_data_width   = DEF_DATA_WIDTH,
    parameter int unsigned p_rom_latency  = DEF_ROM_LATENCY,
    parameter int unsigned p_starve_width = 8,
    parameter int unsigned p_max_starve   = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vga_req,
    input  logic [p_addr_width-1:0] vga_addr,
    output logic                    vga_rvalid,
    output logic [p_data_width-1:0] vga_rdata,
    input  logic                    aux_req,
    input  logic [p_addr_width-1:0] aux_addr,
    output logic                    aux_gnt,
    output logic                    aux_rvalid,
    output logic [p_data_width-1:0] aux_rdata,
    output logic                    aux_starved,
    output logic [p_addr_width-1:0] rom_addr,
    input  logic [p_data_width-1:0] rom_q
);

    localparam logic [p_starve_width-1:0] CNT_ONE    = p_starve_width'(1);
    localparam logic [p_starve_width-1:0] CNT_SAT    = '1;
    localparam logic [p_starve_width-1:0] STARVE_THR = p_starve_width'(p_max_starve);

    logic                      vga_win_s;
    logic                      aux_gnt_s;
    logic [p_addr_width-1:0]   rom_addr_r;
    logic [p_starve_width-1:0] aux_wait_cnt_r;
    logic [p_starve_width-1:0] aux_wait_cnt_nxt_s;
    logic                      aux_starved_r;
    logic                      aux_starved_nxt_s;
    tag_t                      tag_in_s;
    tag_t                      tag_out_s;

    // Fixed-priority arbitration; aux is never granted while reset is asserted.
    always_comb begin
        vga_win_s = 1'b0;
        aux_gnt_s = 1'b0;
        if (vga_req) begin
            vga_win_s = 1'b1;
        end else if (aux_req) begin
            aux_gnt_s = reset;
        end else begin
            vga_win_s = 1'b0;
            aux_gnt_s = 1'b0;
        end
    end

    // Issue register: the winner's address goes to the ROM, idle cycles hold it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_r <= '0;
        end else if (vga_win_s) begin
            rom_addr_r <= vga_addr;
        end else if (aux_gnt_s) begin
            rom_addr_r <= aux_addr;
        end else begin
            rom_addr_r <= rom_addr_r;
        end
    end

    // Next-state of the aux wait counter (saturating) and the sticky starved flag.
    always_comb begin
        aux_wait_cnt_nxt_s = aux_wait_cnt_r;
        aux_starved_nxt_s  = aux_starved_r;
        if (aux_gnt_s || !aux_req) begin
            aux_wait_cnt_nxt_s = '0;
        end else if (aux_wait_cnt_r == CNT_SAT) begin
            aux_wait_cnt_nxt_s = aux_wait_cnt_r;
        end else begin
            aux_wait_cnt_nxt_s = aux_wait_cnt_r + CNT_ONE;
        end
        if (aux_gnt_s) begin
            aux_starved_nxt_s = 1'b0;
        end else if (aux_wait_cnt_nxt_s >= STARVE_THR) begin
            aux_starved_nxt_s = 1'b1;
        end else begin
            aux_starved_nxt_s = aux_starved_r;
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aux_wait_cnt_r <= '0;
            aux_starved_r  <= 1'b0;
        end else begin
            aux_wait_cnt_r <= aux_wait_cnt_nxt_s;
            aux_starved_r  <= aux_starved_nxt_s;
        end
    end

    assign tag_in_s = tag_encode(vga_win_s, aux_gnt_s);

    // One stage for the issue register plus one per ROM latency cycle.
    rom_tag_pipe #(
        .p_depth (1 + p_rom_latency)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign rom_addr    = rom_addr_r;
    assign aux_gnt     = aux_gnt_s;
    assign aux_starved = aux_starved_r;
    assign vga_rvalid  = (tag_out_s == TAG_VGA);
    assign aux_rvalid  = (tag_out_s == TAG_AUX);
    assign vga_rdata   = rom_q;
    assign aux_rdata   = rom_q;

endmodule

// File: tb/tb_rom_port_scheduler.sv
// Directed bench for rom_port_scheduler with a 2-cycle registered ROM model
// returning addr ^ 24'hABCDEF.
module tb_rom_port_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_rvalid;
    logic [23:0] vga_rdata;
    logic        aux_req;
    logic [15:0] aux_addr;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [23:0] aux_rdata;
    logic        aux_starved;
    logic [15:0] rom_addr;
    logic [23:0] rom_q;
    logic [15:0] rom_addr_q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_port_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .aux_req     (aux_req),
        .aux_addr    (aux_addr),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .aux_rdata   (aux_rdata),
        .aux_starved (aux_starved),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q)
    );

    // ROM model: address register then output register.
    always_ff @(posedge clk) begin
        rom_addr_q <= rom_addr;
        rom_q      <= {8'h00, rom_addr_q} ^ 24'hABCDEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the edge, then move to mid-cycle.
    task automatic drive(input logic rst, input logic vr, input logic [15:0] va,
                         input logic ar, input logic [15:0] aa);
        @(posedge clk);
        #1;
        reset    = rst;
        vga_req  = vr;
        vga_addr = va;
        aux_req  = ar;
        aux_addr = aa;
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        vga_req  = 1'b1;
        vga_addr = 16'h1234;
        aux_req  = 1'b1;
        aux_addr = 16'h0300;

        // Reset held with both requesters active
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 16'h1234, 1'b1, 16'h0300);
            chk("rst_rom_addr", 32'(rom_addr), 32'h0);
            chk("rst_vga_rvalid", 32'(vga_rvalid), 32'h0);
            chk("rst_aux_rvalid", 32'(aux_rvalid), 32'h0);
            chk("rst_aux_gnt", 32'(aux_gnt), 32'h0);
            chk("rst_aux_starved", 32'(aux_starved), 32'h0);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        // Single VGA read: valid exactly three cycles later
        drive(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            if (k == 1) chk("lat_rom_addr", 32'(rom_addr), 32'h0010);
            chk("lat_vga_rvalid", 32'(vga_rvalid), (k == 3) ? 32'h1 : 32'h0);
            chk("lat_aux_rvalid", 32'(aux_rvalid), 32'h0);
            if (k == 3) chk("lat_vga_rdata", 32'(vga_rdata), 32'h00ABCDFF);
        end

        // VGA priority over a held aux request
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 16'h0020 + 16'(k), 1'b1, 16'h0200);
            chk("pri_aux_gnt_blocked", 32'(aux_gnt), 32'h0);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0200);
        chk("pri_aux_gnt", 32'(aux_gnt), 32'h1);
        chk("pri_aux_starved", 32'(aux_starved), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            chk("pri_aux_rvalid", 32'(aux_rvalid), (k == 3) ? 32'h1 : 32'h0);
            chk("pri_vga_rvalid", 32'(vga_rvalid), (k <= 2) ? 32'h1 : 32'h0);
            if (k == 1) chk("pri_vga_rdata_23", 32'(vga_rdata), 32'h00ABCDCC);
            if (k == 2) chk("pri_vga_rdata_24", 32'(vga_rdata), 32'h00ABCDCB);
            if (k == 3) chk("pri_aux_rdata", 32'(aux_rdata), 32'h00ABCFEF);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        // Back-to-back VGA reads 0..7
        for (int i = 0; i <= 11; i++) begin
            drive(1'b1, (i < 8) ? 1'b1 : 1'b0, 16'(i), 1'b0, 16'h0);
            if (i >= 3 && i <= 10) begin
                chk("b2b_vga_rvalid", 32'(vga_rvalid), 32'h1);
                chk("b2b_vga_rdata", 32'(vga_rdata), 32'(24'(i - 3) ^ 24'hABCDEF));
            end else begin
                chk("b2b_vga_rvalid_idle", 32'(vga_rvalid), 32'h0);
            end
            chk("b2b_aux_rvalid", 32'(aux_rvalid), 32'h0);
        end

        // Starvation: aux held against 300 cycles of VGA
        for (int k = 1; k <= 300; k++) begin
            drive(1'b1, 1'b1, 16'(k), 1'b1, 16'h0400);
            chk("stv_aux_gnt", 32'(aux_gnt), 32'h0);
            chk("stv_aux_starved", 32'(aux_starved), (k >= 201) ? 32'h1 : 32'h0);
            if (k == 200 || k == 201 || k == 256 || k == 257 || k == 300)
                chk("stv_wait_cnt", 32'(dut.aux_wait_cnt_r), (k - 1 > 255) ? 32'd255 : 32'(k - 1));
        end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0400);
        chk("stv_release_gnt", 32'(aux_gnt), 32'h1);
        chk("stv_release_starved", 32'(aux_starved), 32'h1);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("stv_cleared", 32'(aux_starved), 32'h0);
        chk("stv_cnt_cleared", 32'(dut.aux_wait_cnt_r), 32'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("stv_aux_rvalid", 32'(aux_rvalid), 32'h1);
        chk("stv_vga_rvalid", 32'(vga_rvalid), 32'h0);
        chk("stv_aux_rdata", 32'(aux_rdata), 32'h00ABC9EF);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        // Reset mid-flight discards in-flight reads
        drive(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 16'h0041, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            drive((k < 2) ? 1'b0 : 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            chk("mid_vga_rvalid", 32'(vga_rvalid), 32'h0);
            chk("mid_aux_rvalid", 32'(aux_rvalid), 32'h0);
            if (k < 2) chk("mid_rom_addr", 32'(rom_addr), 32'h0);
        end
        drive(1'b1, 1'b1, 16'h0055, 1'b0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            chk("resume_vga_rvalid", 32'(vga_rvalid), (k == 3) ? 32'h1 : 32'h0);
            if (k == 3) chk("resume_vga_rdata", 32'(vga_rdata), 32'h00ABCDBA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
